// File: rtl/gate_test_sequencer_pkg.sv
// Shared types and constants for the gate test sequencer: FSM state encoding,
// reference truth tables for the basic gate family and a small counter helper.
package gate_test_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bit i holds the expected output for vector index i, where (a,b) = (i[0], i[1])
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    localparam logic [1:0] LAST_IDX = 2'd3;
    localparam logic [2:0] MAX_ERR  = 3'd4;

    function automatic logic [2:0] err_inc(input logic [2:0] cnt);
        logic [2:0] res;
        if (cnt == MAX_ERR) begin
            res = cnt;
        end else begin
            res = cnt + 3'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Settle timer: cleared by load, counts while enabled, and flags expire when
// the count reaches SETTLE_CYCLES-1.
module gate_test_sequencer_settle_timer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load clears, enable increments, otherwise hold
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST_CNT);

endmodule

// File: rtl/gate_test_sequencer.sv
// Drives a 2-input gate through vectors 00,10,01,11, waits SETTLE_CYCLES per
// vector, samples gate_x and checks it against a captured 4-bit truth table.
module gate_test_sequencer
    import gate_test_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] truth_table,
    input  logic       gate_x,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] table_q, table_d;
    logic [2:0] err_q, err_d;
    logic [3:0] mask_q, mask_d;
    logic       gate_a_q, gate_a_d;
    logic       gate_b_q, gate_b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       tmr_load_s;
    logic       tmr_en_s;
    logic       tmr_expire_s;

    gate_test_sequencer_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load_s),
        .en     (tmr_en_s),
        .expire (tmr_expire_s)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        table_d    = table_q;
        err_d      = err_q;
        mask_d     = mask_q;
        gate_a_d   = gate_a_q;
        gate_b_d   = gate_b_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        tmr_load_s = 1'b1;
        tmr_en_s   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    table_d  = truth_table;
                    idx_d    = 2'd0;
                    err_d    = 3'd0;
                    mask_d   = 4'd0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SETTLE: begin
                tmr_load_s = 1'b0;
                tmr_en_s   = 1'b1;
                if (tmr_expire_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (gate_x != table_q[idx_q]) begin
                    mask_d[idx_q] = 1'b1;
                    err_d         = err_inc(err_q);
                end else begin
                    err_d = err_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    pass_d   = (err_d == 3'd0);
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                end else begin
                    state_d  = ST_SETTLE;
                    idx_d    = idx_q + 2'd1;
                    gate_a_d = idx_d[0];
                    gate_b_d = idx_d[1];
                end
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b0;
                pass_d   = 1'b0;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            table_q  <= 4'd0;
            err_q    <= 3'd0;
            mask_q   <= 4'd0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            table_q  <= table_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign gate_a    = gate_a_q;
    assign gate_b    = gate_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomized bench for gate_test_sequencer: a cycle-indexed reference model
// predicts vectors, status and results for a slow (4) and a fast (1) settle instance.
module tb_gate_test_sequencer;
    import gate_test_sequencer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, start1;
    logic [3:0] tt4, tt1;
    logic       gx4, gx1;
    logic       a4, b4, busy4, done4, pass4;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err4, err1;
    logic [3:0] mask4, mask1;

    int checks   = 0;
    int failures = 0;

    gate_test_sequencer #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start4), .truth_table(tt4), .gate_x(gx4),
        .gate_a(a4), .gate_b(b4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .fail_mask(mask4)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .truth_table(tt1), .gate_x(gx1),
        .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behaviour of the modelled gate: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 stuck-0, 6 stuck-1
    function automatic logic gate_fn(input int code, input logic a, input logic b);
        case (code)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] exp_mask(input int code, input logic [3:0] tt);
        logic [3:0] m;
        logic [1:0] v;
        m = 4'd0;
        for (int i = 0; i < 4; i++) begin
            v = i[1:0];
            m[i] = (gate_fn(code, v[0], v[1]) != tt[i]);
        end
        return m;
    endfunction

    function automatic int popc(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    task automatic check_reset4(input string tag);
        check({tag, "_a"}, a4, 0);
        check({tag, "_b"}, b4, 0);
        check({tag, "_busy"}, busy4, 0);
        check({tag, "_done"}, done4, 0);
        check({tag, "_pass"}, pass4, 0);
        check({tag, "_err"}, err4, 0);
        check({tag, "_mask"}, mask4, 0);
    endtask

    // One run on the settle=4 instance; optional spurious start and mid-run reset
    task automatic run4(input logic [3:0] tt, input int code, input int mid_start, input int abort_at);
        int v;
        logic [3:0] em;
        em = exp_mask(code, tt);
        @(negedge clk);
        start4 = 1'b1;
        tt4    = tt;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            v      = c / 5;
            start4 = (c == mid_start);
            tt4    = 4'($urandom);
            gx4    = (c % 5 == 4) ? gate_fn(code, v[0], v[1]) : 1'($urandom);
            check("run_a", a4, v[0]);
            check("run_b", b4, v[1]);
            check("run_busy", busy4, 1);
            check("run_done", done4, 0);
            if (c == abort_at) begin
                #2 rst = 1'b1;
                #1 check_reset4("async_rst");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        @(negedge clk);
        start4 = 1'b0;
        check("end_done", done4, 1);
        check("end_busy", busy4, 0);
        check("end_a", a4, 0);
        check("end_b", b4, 0);
        check("end_pass", pass4, (em == 4'd0));
        check("end_err", err4, popc(em));
        check("end_mask", mask4, em);
        @(negedge clk);
        check("hold_done", done4, 1);
        check("hold_mask", mask4, em);
    endtask

    // Back-to-back runs on the settle=1 instance with start held high
    task automatic run1_held(input int nruns);
        int p;
        int v;
        int code_cur;
        logic [3:0] tt_cur;
        logic [3:0] em;
        code_cur = $urandom_range(0, 6);
        tt_cur   = 4'($urandom);
        @(negedge clk);
        start1 = 1'b1;
        tt1    = tt_cur;
        for (int c = 0; c < nruns * 9; c++) begin
            @(negedge clk);
            p = c % 9;
            v = p / 2;
            if (p < 8) begin
                check("held_a", a1, v[0]);
                check("held_b", b1, v[1]);
                check("held_busy", busy1, 1);
                check("held_done", done1, 0);
                gx1 = (p % 2 == 1) ? gate_fn(code_cur, v[0], v[1]) : 1'($urandom);
                tt1 = 4'($urandom);
            end else begin
                em = exp_mask(code_cur, tt_cur);
                check("held_end_done", done1, 1);
                check("held_end_busy", busy1, 0);
                check("held_end_pass", pass1, (em == 4'd0));
                check("held_end_err", err1, popc(em));
                check("held_end_mask", mask1, em);
                code_cur = $urandom_range(0, 6);
                tt_cur   = 4'($urandom);
                tt1      = tt_cur;
            end
        end
        start1 = 1'b0;
        @(negedge clk);
        check("held_final_done", done1, 1);
    endtask

    initial begin
        rst    = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        tt4    = 4'd0;
        tt1    = 4'd0;
        gx4    = 1'b0;
        gx1    = 1'b0;
        #12;
        check_reset4("reset");
        check("reset1_busy", busy1, 0);
        check("reset1_done", done1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (3) @(negedge clk);
        check("idle_busy", busy4, 0);
        check("idle_done", done4, 0);

        run4(TT_AND, 0, -1, -1);
        run4(TT_AND, 5, -1, -1);
        run4(TT_AND, 2, -1, -1);
        run4(TT_XOR, 2, -1, -1);
        run4(TT_AND, 0, 11, -1);
        run4(TT_AND, 6, -1, 7);
        run4(TT_NAND, 3, -1, -1);
        repeat (6) run4(4'($urandom), $urandom_range(0, 6), -1, -1);

        run1_held(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
